multiplier: RTL and testbench
=============================

// Module: multiplier
// PURPOSE
//  Sequential 32x32 signed (two's-complement) multiplier: 64-bit product in {Aval,Bval}.
//  Add-and-shift, one multiplier bit per clock. Final step subtracts for the sign bit.
//  A Run level starts an operation; ready flags idle or result valid.
//  Standalone arithmetic unit for a datapath/controller that polls ready.
// PARAMETERS
//  none (width fixed at 32; product 64)
// PORTS
//  Clk      in   1   system clock, rising-edge active; the block's only clock
//  Reset_n  in   1   reset, asynchronous, active-low
//  Run      in   1   start request (level)
//  mulA     in   32  multiplicand, signed; latched at start
//  mulB     in   32  multiplier, signed; latched at start
//  Aval     out  32  accumulator; product[63:32] when ready=1 after an operation
//  Bval     out  32  multiplier shift register; product[31:0] when done
//  X        out  1   sign-extension bit of accumulator; equals Aval[31] when done
//  ready    out  1   1 = idle/result valid, 0 = busy
// BEHAVIOUR
//  Reset (Reset_n=0, async, any state): state=IDLE, Aval=0, Bval=0, X=0, ready=1.
//  Internal: Sreg[31:0] (latched mulA), cnt[5:0], state {IDLE, LOAD, CALC, DONE}.
//  IDLE: ready=1, registers hold. Run=1 sampled at a rising edge -> LOAD.
//  LOAD (1 cycle): Aval=0, X=0, Bval=mulB, Sreg=mulA, cnt=0, ready=0 -> CALC.
//  CALC (32 cycles, cnt 0..31), each cycle:
//   - cnt<31 and Bval[0]=1: {X,Aval} = sext33(Aval) + sext33(Sreg).
//   - cnt=31 and Bval[0]=1: {X,Aval} = sext33(Aval) - sext33(Sreg).
//   - Bval[0]=0: {X,Aval} = sext33(Aval), i.e. no add.
//   - Then, same cycle: arithmetic right shift of {X,Aval,Bval} by 1; X keeps its value.
//   - cnt++; after the cnt=31 step -> DONE.
//  DONE: ready=1; Aval/Bval/X hold the product.
//   - Stays in DONE while Run=1; a held Run never restarts.
//   - Run=0 -> IDLE (outputs hold). A new Run=1 then starts again.
//  Latency: Run sampled at edge N -> ready=0 at N+1 (LOAD) -> ready=1 after edge N+33.
//  mulA/mulB changes after LOAD are ignored. Run changes during LOAD/CALC are ignored.
//  Intermediate Aval/Bval are visible in CALC. Consumers use them only when ready=1.
//  Overflow impossible: full 64-bit two's-complement product, incl. (-2^31)*(-2^31).
//  Reset_n low mid-CALC aborts at once to the reset values; no partial result kept.
// TESTING
//  1) mulA=-10, mulB=12, Run 0->1 held:
//     -> ready=0 for 33 cycles, then Aval=FFFFFFFF, Bval=FFFFFF88, X=1 (-120).
//     -> Holding Run=1 gives no restart.
//  2) mulA=7, mulB=-3:
//     -> {Aval,Bval}=FFFFFFFF_FFFFFFEB, X=1.
//  3) mulA=mulB=32'h80000000:
//     -> {Aval,Bval}=40000000_00000000, X=0.
//  4) mulA=-1, mulB=-1:
//     -> 00000000_00000001. Also mulA=0, mulB=12345 -> 0.
//  5) Latching/restart:
//     - mulA changes mid-CALC -> result unaffected.
//     - Run low 1 cycle then high -> new operation with the new operands.
//  6) Reset_n low mid-CALC, async with no clock edge:
//     -> Aval=Bval=0, X=0, ready=1 at once; after release, Run=1 works normally.

Source files
------------

// File: rtl/multiplier.sv
// ----------------------------------------------------------------------------
// multiplier
//   Sequential 32x32 signed (two's-complement) add-and-shift multiplier.
//   Retires one multiplier bit per clock. The last step subtracts the
//   multiplicand, because the multiplier's sign bit has weight -2^31.
//   The 64-bit product appears in {Aval, Bval} once ready returns high.
//
// Ports
//   Clk      in   1   rising-edge clock
//   Reset_n  in   1   asynchronous active-low reset
//   Run      in   1   start request (level); sampled only while idle
//   mulA     in   32  signed multiplicand, latched when an operation starts
//   mulB     in   32  signed multiplier, latched when an operation starts
//   Aval     out  32  accumulator; product[63:32] when done
//   Bval     out  32  multiplier shift register; product[31:0] when done
//   X        out  1   accumulator sign-extension bit; equals Aval[31] when done
//   ready    out  1   1 = idle or result valid, 0 = busy
// ----------------------------------------------------------------------------
module multiplier (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Run,
    input  logic [31:0] mulA,
    input  logic [31:0] mulB,
    output logic [31:0] Aval,
    output logic [31:0] Bval,
    output logic        X,
    output logic        ready
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] Sreg;
    logic [5:0]  cnt;
    logic [32:0] a_ext;
    logic [32:0] s_ext;
    logic [32:0] sum;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and ready decode
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (Run) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                state_n = CALC;
            end
            CALC: begin
                if (cnt == 6'd31) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                ready = 1'b1;
                // A held Run never restarts; Run must drop to 0 first.
                if (!Run) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // 33-bit partial sum. The top bit becomes the new X and is shifted into
    // the accumulator MSB, so the arithmetic shift never overflows.
    always_comb begin
        a_ext = {Aval[31], Aval};
        s_ext = {Sreg[31], Sreg};
        sum   = a_ext;
        if (Bval[0]) begin
            if (cnt == 6'd31) begin
                sum = a_ext - s_ext;
            end else begin
                sum = a_ext + s_ext;
            end
        end
    end

    // Datapath. Operands are captured on the edge that samples Run, so the
    // inputs only have to be valid alongside the start request.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Aval <= '0;
            Bval <= '0;
            X    <= 1'b0;
            Sreg <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        Aval <= '0;
                        X    <= 1'b0;
                        Bval <= mulB;
                        Sreg <= mulA;
                        cnt  <= '0;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                CALC: begin
                    X    <= sum[32];
                    Aval <= {sum[32], sum[32:1]};
                    Bval <= {sum[0], Bval[31:1]};
                    cnt  <= cnt + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// ----------------------------------------------------------------------------
// tb_multiplier
//   Self-checking bench for the sequential signed multiplier. Expected
//   products come from plain 64-bit signed arithmetic on the operands.
// ----------------------------------------------------------------------------
module tb_multiplier;

    logic        Clk;
    logic        Reset_n;
    logic        Run;
    logic [31:0] mulA;
    logic [31:0] mulB;
    logic [31:0] Aval;
    logic [31:0] Bval;
    logic        X;
    logic        ready;

    int checks = 0;
    int errors = 0;

    multiplier dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Run     (Run),
        .mulA    (mulA),
        .mulB    (mulB),
        .Aval    (Aval),
        .Bval    (Bval),
        .X       (X),
        .ready   (ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // Drops Run for one cycle (leaves DONE), then starts an operation and
    // counts the sampled cycles with ready=0. Leaves Run high on return.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  output int busy, output bit timeout);
        busy    = 0;
        timeout = 1'b0;
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        mulA = a;
        mulB = b;
        Run  = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (ready === 1'b1) return;
            busy++;
        end
        timeout = 1'b1;
    endtask

    task automatic check_result(input string name, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        exp = ref_product(a, b);
        checks++;
        if ({Aval, Bval} !== exp) begin
            errors++;
            $display("FAIL %s product a=%h b=%h got %h want %h", name, a, b, {Aval, Bval}, exp);
        end
        checks++;
        if (X !== exp[63]) begin
            errors++;
            $display("FAIL %s X got %b want %b", name, X, exp[63]);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        Run     = 1'b0;
        mulA    = '0;
        mulB    = '0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Aval, Bval, X, ready} !== {64'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got A=%h B=%h X=%b r=%b want 0/0/0/1", Aval, Bval, X, ready);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %b want 1", ready);
        end
    endtask

    task automatic test_basic_latency();
        int busy;
        bit to;
        logic [63:0] held;
        start_and_wait(32'hFFFFFFF6, 32'd12, busy, to);
        checks++;
        if (to || busy != 33) begin
            errors++;
            $display("FAIL latency got %0d timeout=%0b want 33", busy, to);
        end
        checks++;
        if ({Aval, Bval, X} !== {32'hFFFFFFFF, 32'hFFFFFF88, 1'b1}) begin
            errors++;
            $display("FAIL neg10x12 got %h_%h X=%b want FFFFFFFF_FFFFFF88 X=1", Aval, Bval, X);
        end
        // Run stays high: no restart allowed
        held = {Aval, Bval};
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            checks++;
            if (ready !== 1'b1 || {Aval, Bval} !== held) begin
                errors++;
                $display("FAIL no_restart cyc %0d got r=%b %h want r=1 %h", i, ready, {Aval, Bval}, held);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [63:0] ve [5];
        int busy;
        bit to;
        va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD; ve[0] = 64'hFFFFFFFF_FFFFFFEB;
        va[1] = 32'h80000000; vb[1] = 32'h80000000; ve[1] = 64'h40000000_00000000;
        va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF; ve[2] = 64'h00000000_00000001;
        va[3] = 32'd0;        vb[3] = 32'd12345;    ve[3] = 64'h0;
        va[4] = 32'h7FFFFFFF; vb[4] = 32'h80000000; ve[4] = 64'hC0000000_80000000;
        for (int i = 0; i < 5; i++) begin
            start_and_wait(va[i], vb[i], busy, to);
            checks++;
            if (to || busy != 33) begin
                errors++;
                $display("FAIL dir_latency_%0d got %0d timeout=%0b want 33", i, busy, to);
            end
            checks++;
            if ({Aval, Bval} !== ve[i] || X !== ve[i][63]) begin
                errors++;
                $display("FAIL dir_%0d got %h X=%b want %h X=%b", i, {Aval, Bval}, X, ve[i], ve[i][63]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        int busy;
        bit to;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) b = 32'h80000000 | ($urandom & 32'h3);
            start_and_wait(a, b, busy, to);
            checks++;
            if (to || busy != 33) begin
                errors++;
                $display("FAIL rnd_latency_%0d got %0d timeout=%0b want 33", i, busy, to);
            end
            check_result("rnd", a, b);
        end
    endtask

    task automatic test_latching();
        logic [31:0] a;
        logic [31:0] b;
        int busy;
        bit to;
        a = 32'h12345678;
        b = 32'hFEDCBA98;
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        mulA = a;
        mulB = b;
        Run  = 1'b1;
        @(negedge Clk);
        // Operands and Run change during LOAD/CALC; all must be ignored.
        busy = 1;
        to   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (i == 2) begin
                mulA = ~a;
                mulB = 32'h5;
                Run  = 1'b0;
            end
            if (i == 6) Run = 1'b1;
            if (ready === 1'b1) begin
                to = 1'b0;
                break;
            end
            busy++;
        end
        checks++;
        if (to || busy != 33) begin
            errors++;
            $display("FAIL latch_latency got %0d timeout=%0b want 33", busy, to);
        end
        check_result("latch", a, b);
    endtask

    task automatic test_back_to_back();
        int busy;
        bit to;
        start_and_wait(32'd1000, 32'hFFFFFC18, busy, to);
        check_result("b2b_first", 32'd1000, 32'hFFFFFC18);
        // start_and_wait drops Run for exactly one cycle before restarting
        start_and_wait(32'hFFFF0001, 32'h0001FFFF, busy, to);
        checks++;
        if (to || busy != 33) begin
            errors++;
            $display("FAIL b2b_latency got %0d timeout=%0b want 33", busy, to);
        end
        check_result("b2b_second", 32'hFFFF0001, 32'h0001FFFF);
    endtask

    task automatic test_async_reset();
        int busy;
        bit to;
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        mulA = 32'h0BADF00D;
        mulB = 32'hFFFFFFFF;
        Run  = 1'b1;
        repeat (12) @(negedge Clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midcalc_busy got %b want 0", ready);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({Aval, Bval, X, ready} !== {64'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got A=%h B=%h X=%b r=%b want 0/0/0/1", Aval, Bval, X, ready);
        end
        Run = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        start_and_wait(32'hFFFFFFF9, 32'd9, busy, to);
        checks++;
        if (to || busy != 33) begin
            errors++;
            $display("FAIL post_reset_latency got %0d timeout=%0b want 33", busy, to);
        end
        check_result("post_reset", 32'hFFFFFFF9, 32'd9);
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_directed();
        test_random();
        test_latching();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
